tdpram_bist_ctrl: RTL

- Single-port built-in self-test initiator that drives one port of the team's true dual-port RAM (WEN/ADDR/DIN out, DOUT in).
- Runs a three-pass march over the full address space: write pattern, read-modify-write with the complement, then read-only verify.
- Checks every returned word against a latency-aligned expected value and reports pass/fail with first-error capture.
- Sits beside the RAM in the RAM clock domain; one instance per RAM port under test.

---
 rtl/tdpram_bist_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/tdpram_bist_ctrl.sv
// March BIST initiator for one port of the true dual-port RAM: write P(a), read-first RMW with ~P(a), read-verify.
// Define TDPRAM_BIST_ERRCNT_EN to keep running after a mismatch and count all mismatches instead of stopping.
module tdpram_bist_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 1,
    parameter int SEED         = 15,
    parameter int STEP         = 2,
    localparam int AD_WIDTH    = $clog2(DEPTH)
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  START_I,
    output logic                  BUSY_O,
    output logic                  DONE_O,
    output logic                  PASS_O,
    output logic [AD_WIDTH-1:0]   ERR_ADDR_O,
    output logic [DATA_WIDTH-1:0] ERR_EXP_O,
    output logic [DATA_WIDTH-1:0] ERR_GOT_O,
    output logic [15:0]           ERR_CNT_O,
    output logic                  WEN_O,
    output logic [AD_WIDTH-1:0]   ADDR_O,
    output logic [DATA_WIDTH-1:0] DIN_O,
    input  logic [DATA_WIDTH-1:0] DOUT_I
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_RMW   = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int DC_W = $clog2(READ_LATENCY + 1);
    localparam logic [AD_WIDTH-1:0]   LAST_ADDR  = AD_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] SEED_W     = DATA_WIDTH'(SEED);
    localparam logic [DATA_WIDTH-1:0] STEP_W     = DATA_WIDTH'(STEP);
    localparam logic [DC_W-1:0]       DRAIN_LAST = DC_W'(READ_LATENCY);

    logic [2:0]            state;
    logic [AD_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0] pat;
    logic [DC_W-1:0]       drain_cnt;

    logic                  pipe_v [READ_LATENCY];
    logic [AD_WIDTH-1:0]   pipe_a [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_e [READ_LATENCY];

    logic                  err_seen;
    logic [AD_WIDTH-1:0]   err_addr;
    logic [DATA_WIDTH-1:0] err_exp;
    logic [DATA_WIDTH-1:0] err_got;
    logic [15:0]           err_cnt;

    logic                  at_last;
    logic [AD_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0] pat_nxt;
    logic                  issue;
    logic [DATA_WIDTH-1:0] exp_issue;
    logic                  mismatch;
    logic                  abort;
    logic                  start_ok;

    // Pattern is tracked incrementally so no multiplier is needed; wrap is explicit for any DEPTH.
    assign at_last   = (addr == LAST_ADDR);
    assign addr_nxt  = at_last ? '0 : addr + AD_WIDTH'(1);
    assign pat_nxt   = at_last ? SEED_W : pat + STEP_W;
    assign issue     = (state == S_RMW) || (state == S_RD);
    assign exp_issue = (state == S_RMW) ? pat : ~pat;
    assign mismatch  = pipe_v[READ_LATENCY-1] && (DOUT_I != pipe_e[READ_LATENCY-1]);
    assign start_ok  = START_I && ((state == S_IDLE) || (state == S_DONE));

`ifdef TDPRAM_BIST_ERRCNT_EN
    assign abort = 1'b0;
`else
    assign abort = mismatch;
`endif

    // A mismatch suppresses the write issued in the same cycle so a failing RAM is not disturbed further.
    assign WEN_O      = ((state == S_WR) || (state == S_RMW)) && !abort;
    assign ADDR_O     = addr;
    assign DIN_O      = (state == S_WR) ? pat : (state == S_RMW) ? ~pat : '0;
    assign BUSY_O     = (state == S_WR) || (state == S_RMW) || (state == S_RD) || (state == S_DRAIN);
    assign DONE_O     = (state == S_DONE);
    assign PASS_O     = (state == S_DONE) && !err_seen;
    assign ERR_ADDR_O = err_addr;
    assign ERR_EXP_O  = err_exp;
    assign ERR_GOT_O  = err_got;
    assign ERR_CNT_O  = err_cnt;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state     <= S_IDLE;
            addr      <= '0;
            pat       <= SEED_W;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START_I) begin
                        state <= S_WR;
                        addr  <= '0;
                        pat   <= SEED_W;
                    end
                end
                S_WR: begin
                    addr <= addr_nxt;
                    pat  <= pat_nxt;
                    if (at_last) state <= S_RMW;
                end
                S_RMW: begin
                    if (abort) begin
                        state <= S_DONE;
                        addr  <= '0;
                        pat   <= SEED_W;
                    end else begin
                        addr <= addr_nxt;
                        pat  <= pat_nxt;
                        if (at_last) state <= S_RD;
                    end
                end
                S_RD: begin
                    if (abort) begin
                        state <= S_DONE;
                        addr  <= '0;
                        pat   <= SEED_W;
                    end else begin
                        addr <= addr_nxt;
                        pat  <= pat_nxt;
                        if (at_last) begin
                            state     <= S_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort || (drain_cnt == DRAIN_LAST)) state <= S_DONE;
                    else drain_cnt <= drain_cnt + DC_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Expected values travel alongside the RAM read so each compare lines up with its DOUT_I word.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
                pipe_e[i] <= '0;
            end
        end else begin
            pipe_v[0] <= issue && !abort;
            pipe_a[0] <= addr;
            pipe_e[0] <= exp_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1] && !abort;
                pipe_a[i] <= pipe_a[i-1];
                pipe_e[i] <= pipe_e[i-1];
            end
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            err_seen <= 1'b0;
            err_addr <= '0;
            err_exp  <= '0;
            err_got  <= '0;
            err_cnt  <= '0;
        end else if (start_ok) begin
            err_seen <= 1'b0;
            err_addr <= '0;
            err_exp  <= '0;
            err_got  <= '0;
            err_cnt  <= '0;
        end else if (mismatch) begin
            if (!err_seen) begin
                err_seen <= 1'b1;
                err_addr <= pipe_a[READ_LATENCY-1];
                err_exp  <= pipe_e[READ_LATENCY-1];
                err_got  <= DOUT_I;
            end
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule
